// File: rtl/ram32_req_adapter.sv
// Byte-addressed valid/ready request adapter for a RAM32x32 macro with a registered Do.
// Generates byte enables and replicated write data, and returns one in-order response per request.
module ram32_req_adapter #(
    parameter int AW = 7,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [1:0]    req_size,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_write,
    output logic          ram_EN,
    output logic [3:0]    ram_WE,
    output logic [DW-1:0] ram_Di,
    output logic [AW-3:0] ram_A,
    input  logic [DW-1:0] ram_Do
);

    // state | meaning
    // IDLE  | no response outstanding; ready once alive
    // RESP  | response for the last accepted request is on the rsp port
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    if (DW != 32) begin : g_bad_dw
        $error("ram32_req_adapter: DW must be 32");
    end

    state_t     state_q, state_d;
    logic       alive_q;
    logic       write_q, write_d;
    logic [1:0] size_q, size_d;
    logic [1:0] off_q, off_d;
    logic       err_q, err_d;

    logic       accept;
    logic       req_err;
    logic [3:0] we_mask;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            alive_q <= 1'b0;
            write_q <= 1'b0;
            size_q  <= 2'd0;
            off_q   <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
            write_q <= write_d;
            size_q  <= size_d;
            off_q   <= off_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'd0:    req_err = 1'b0;
            2'd1:    req_err = req_addr[0];
            2'd2:    req_err = (req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: req_ready = alive_q;
            RESP: begin
                rsp_valid = 1'b1;
                req_ready = rsp_ready;
            end
            default: req_ready = 1'b0;
        endcase

        accept = req_valid & req_ready;

        if (state_q == IDLE) begin
            if (accept) state_d = RESP;
        end else if (rsp_ready) begin
            // a completing response with a new request keeps us in RESP
            state_d = accept ? RESP : IDLE;
        end
    end

    always_comb begin
        write_d = write_q;
        size_d  = size_q;
        off_d   = off_q;
        err_d   = err_q;
        if (accept) begin
            write_d = req_write;
            size_d  = req_size;
            off_d   = req_addr[1:0];
            err_d   = req_err;
        end
    end

    always_comb begin
        we_mask = 4'b0000;
        case (req_size)
            2'd0:    we_mask = 4'b0001 << req_addr[1:0];
            2'd1:    we_mask = req_addr[1] ? 4'b1100 : 4'b0011;
            default: we_mask = 4'b1111;
        endcase

        ram_Di = req_wdata;
        case (req_size)
            2'd0:    ram_Di = {4{req_wdata[7:0]}};
            2'd1:    ram_Di = {2{req_wdata[15:0]}};
            default: ram_Di = req_wdata;
        endcase

        ram_EN = accept & ~req_err;
        ram_WE = (ram_EN & req_write) ? we_mask : 4'b0000;
        ram_A  = req_addr[AW-1:2];
    end

    // Do is only reloaded on EN, so it stays valid for a stalled response
    always_comb begin
        rsp_rdata = '0;
        if (!write_q && !err_q) begin
            case (size_q)
                2'd0: begin
                    case (off_q)
                        2'd0:    rsp_rdata = {24'd0, ram_Do[7:0]};
                        2'd1:    rsp_rdata = {24'd0, ram_Do[15:8]};
                        2'd2:    rsp_rdata = {24'd0, ram_Do[23:16]};
                        default: rsp_rdata = {24'd0, ram_Do[31:24]};
                    endcase
                end
                2'd1:    rsp_rdata = off_q[1] ? {16'd0, ram_Do[31:16]} : {16'd0, ram_Do[15:0]};
                default: rsp_rdata = ram_Do;
            endcase
        end
    end

    assign rsp_err   = err_q;
    assign rsp_write = write_q;

endmodule

// File: tb/tb_ram32_req_adapter.sv
// Scoreboard bench for ram32_req_adapter: a reference memory predicts pins and responses,
// expected responses are queued on accept and compared when the DUT hands them over.
module tb_ram32_req_adapter;

    localparam int AW = 7;

    logic          CLK = 1'b0;
    logic          RESETn;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_write;
    logic          ram_EN;
    logic [3:0]    ram_WE;
    logic [31:0]   ram_Di;
    logic [AW-3:0] ram_A;
    logic [31:0]   ram_Do;

    ram32_req_adapter #(.AW(AW), .DW(32)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_write(rsp_write),
        .ram_EN(ram_EN), .ram_WE(ram_WE), .ram_Di(ram_Di), .ram_A(ram_A), .ram_Do(ram_Do)
    );

    always #5 CLK = ~CLK;

    // RAM32x32 macro model: Do registered on EN, byte-wise write enables
    logic [31:0] mem [32] = '{default: 32'd0};
    always @(posedge CLK) begin
        if (ram_EN) begin
            ram_Do <= mem[ram_A];
            for (int b = 0; b < 4; b++)
                if (ram_WE[b]) mem[ram_A][8*b +: 8] <= ram_Di[8*b +: 8];
        end
    end

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        write;
    } rsp_t;

    rsp_t        sb_q[$];
    int          acc_cyc[$];
    logic [31:0] ref_mem [32] = '{default: 32'd0};
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          pop_cnt  = 0;
    logic        m_alive;
    logic [3:0]  last_we;
    logic [31:0] last_di;
    logic [4:0]  last_a;
    logic        last_en;
    logic [31:0] last_rdata;
    logic        last_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_err(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return off[0];
            2'd2:    return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] exp_we(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    return 4'b0001 << off;
            2'd1:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] w, input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    return {24'd0, w[8*off +: 8]};
            2'd1:    return {16'd0, w[16*off[1] +: 16]};
            default: return w;
        endcase
    endfunction

    always @(posedge CLK) cyc++;

    always @(posedge CLK or negedge RESETn)
        if (!RESETn) m_alive <= 1'b0;
        else         m_alive <= 1'b1;

    always @(negedge RESETn) sb_q.delete();

    // Monitor: sampled on the falling edge, predicts what happens on the next rising edge
    always @(negedge CLK) begin
        logic        v_exp, rdy_exp, acc, e, en;
        logic [1:0]  off;
        logic [3:0]  we;
        logic [4:0]  wa;
        rsp_t        r;
        if (!RESETn) begin
            check_eq("rst_rsp_valid", rsp_valid, 0);
            check_eq("rst_ram_en", ram_EN, 0);
        end else begin
            v_exp   = sb_q.size() != 0;
            rdy_exp = v_exp ? rsp_ready : m_alive;
            check_eq("rsp_valid", rsp_valid, v_exp);
            check_eq("req_ready", req_ready, rdy_exp);
            if (v_exp && rsp_ready) begin
                r = sb_q.pop_front();
                pop_cnt++;
                check_eq("rsp_rdata", rsp_rdata, r.rdata);
                check_eq("rsp_err", rsp_err, r.err);
                check_eq("rsp_write", rsp_write, r.write);
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
            end
            acc = req_valid && rdy_exp;
            off = req_addr[1:0];
            wa  = req_addr[AW-1:2];
            e   = exp_err(req_size, off);
            en  = acc && !e;
            check_eq("ram_en", ram_EN, en);
            if (acc) begin
                last_en = ram_EN;
                acc_cyc.push_back(cyc);
            end
            if (en) begin
                we = req_write ? exp_we(req_size, off) : 4'b0000;
                check_eq("ram_we", ram_WE, we);
                check_eq("ram_a", ram_A, wa);
                last_we = ram_WE;
                last_di = ram_Di;
                last_a  = ram_A;
                for (int b = 0; b < 4; b++)
                    if (we[b]) begin
                        check_eq("ram_di_byte", ram_Di[8*b +: 8], req_wdata[8*(b % (req_size == 2'd0 ? 1 : (req_size == 2'd1 ? 2 : 4))) +: 8]);
                        ref_mem[wa][8*b +: 8] = req_wdata[8*(b % (req_size == 2'd0 ? 1 : (req_size == 2'd1 ? 2 : 4))) +: 8];
                    end
            end
            if (acc) begin
                r.write = req_write;
                r.err   = e;
                r.rdata = (req_write || e) ? 32'd0 : exp_rd(ref_mem[wa], req_size, off);
                sb_q.push_back(r);
            end
        end
    end

    task automatic send(input logic wr, input logic [1:0] sz, input logic [AW-1:0] a, input logic [31:0] d);
        int n;
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        forever begin
            @(negedge CLK);
            if (req_ready) break;
            n++;
            if (n > 50) begin
                check_eq("send_timeout", n, 0);
                break;
            end
        end
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (sb_q.size() != 0) check_eq("drain_timeout", sb_q.size(), 0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESETn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        #2;
        check_eq("reset_req_ready", req_ready, 0);
        check_eq("reset_rsp_err", rsp_err, 0);
        check_eq("reset_rsp_write", rsp_write, 0);
        repeat (2) @(posedge CLK);
        #2 RESETn = 1'b1;
        #1 check_eq("release_req_ready", req_ready, 0);
        @(posedge CLK);
        #1 check_eq("alive_req_ready", req_ready, 1);

        send(1, 2'd2, 7'h08, 32'hDEADBEEF);
        check_eq("w08_we", last_we, 4'b1111);
        check_eq("w08_a", last_a, 2);
        send(0, 2'd2, 7'h08, 32'h0);
        drain();
        check_eq("r08_data", last_rdata, 32'hDEADBEEF);
        check_eq("r08_err", last_err, 0);

        send(1, 2'd2, 7'h0C, 32'h11223344);
        send(1, 2'd0, 7'h0D, 32'h000000A5);
        check_eq("b0d_we", last_we, 4'b0010);
        check_eq("b0d_di", last_di, 32'hA5A5A5A5);
        send(0, 2'd2, 7'h0C, 32'h0);
        drain();
        check_eq("r0c_data", last_rdata, 32'h1122A544);
        send(0, 2'd0, 7'h0D, 32'h0);
        drain();
        check_eq("rb0d_data", last_rdata, 32'h000000A5);

        send(1, 2'd1, 7'h12, 32'h0000BEEF);
        check_eq("h12_we", last_we, 4'b1100);
        send(0, 2'd1, 7'h12, 32'h0);
        drain();
        check_eq("rh12_data", last_rdata, 32'h0000BEEF);
        send(0, 2'd2, 7'h10, 32'h0);
        drain();
        check_eq("r10_upper", last_rdata[31:16], 16'hBEEF);

        send(1, 2'd2, 7'h05, 32'hFFFFFFFF);
        check_eq("mis_w_en", last_en, 0);
        drain();
        check_eq("mis_w_err", last_err, 1);
        check_eq("mis_w_rdata", last_rdata, 0);
        send(1, 2'd1, 7'h03, 32'hFFFFFFFF);
        check_eq("mis_h_en", last_en, 0);
        drain();
        check_eq("mis_h_err", last_err, 1);
        send(0, 2'd3, 7'h0C, 32'h0);
        check_eq("sz3_en", last_en, 0);
        drain();
        check_eq("sz3_err", last_err, 1);
        check_eq("sz3_rdata", last_rdata, 0);
        send(0, 2'd2, 7'h04, 32'h0);
        drain();
        check_eq("r04_unchanged", last_rdata, 32'h0);
        send(0, 2'd2, 7'h00, 32'h0);
        drain();
        check_eq("r00_unchanged", last_rdata, 32'h0);

        acc_cyc.delete();
        fork
            begin
                send(0, 2'd2, 7'h08, 32'h0);
                send(0, 2'd2, 7'h0C, 32'h0);
                send(0, 2'd2, 7'h10, 32'h0);
                send(0, 2'd2, 7'h14, 32'h0);
            end
            begin
                int base, n;
                logic [31:0] held;
                base = pop_cnt;
                n = 0;
                while (pop_cnt < base + 1 && n < 100) begin
                    @(negedge CLK);
                    #1;
                    n++;
                end
                @(posedge CLK);
                #1 rsp_ready = 1'b0;
                held = rsp_rdata;
                repeat (3) begin
                    @(negedge CLK);
                    check_eq("stall_req_ready", req_ready, 0);
                    check_eq("stall_ram_en", ram_EN, 0);
                    check_eq("stall_rdata", rsp_rdata, held);
                    @(posedge CLK);
                end
                #1 rsp_ready = 1'b1;
            end
        join
        drain();
        check_eq("bp_accepts", acc_cyc.size(), 4);
        if (acc_cyc.size() == 4) check_eq("bp_span", acc_cyc[3] - acc_cyc[0], 6);

        send(1, 2'd2, 7'h18, 32'h55AA55AA);
        drain();
        rsp_ready = 1'b0;
        send(0, 2'd2, 7'h18, 32'h0);
        #2 RESETn = 1'b0;
        #1;
        check_eq("midrst_rsp_valid", rsp_valid, 0);
        check_eq("midrst_req_ready", req_ready, 0);
        @(negedge CLK);
        @(posedge CLK);
        #2 RESETn = 1'b1;
        rsp_ready = 1'b1;
        #1 check_eq("rerel_req_ready", req_ready, 0);
        @(posedge CLK);
        #1 check_eq("realive_req_ready", req_ready, 1);
        send(0, 2'd2, 7'h18, 32'h0);
        drain();
        check_eq("r18_after_rst", last_rdata, 32'h55AA55AA);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
